// File: rtl/mdr_asm_pkg.sv
// Shared types, lane mapping and parameter defaults for the MDR byte-to-word assembler.
package mdr_asm_pkg;

   localparam int DEF_BYTE_W = 8;
   localparam int DEF_BYTES  = 2;
   localparam int DEF_ADDR_W = 16;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } asm_state_t;

   // Byte idx of a word lands in lane idx, or mirrored from the top when big-endian.
   function automatic int unsigned lane_index(input int unsigned idx,
                                              input logic        be,
                                              input int unsigned bytes);
      return be ? (bytes - 1 - idx) : idx;
   endfunction

endpackage

// File: rtl/mdr_addr_counter.sv
// Word address register: load beats increment, increment wraps modulo 2^ADDR_W.
// Updates on the same edge as load/inc; no backpressure.
module mdr_addr_counter #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr
);

   always_ff @(posedge clk) begin
      if (rst)       addr <= '0;
      else if (load) addr <= load_val;
      else if (inc)  addr <= addr + ADDR_W'(1);
   end

endmodule

// File: rtl/mdr_word_assembler.sv
// Packs BYTES bytes into a word (optional big-endian via MDR_ASM_ENDIAN_EN); word valid the edge after the last byte/flush.
// Stalls input (in_ready=0) while a word is held awaiting out_ready; one word per BYTES+1 cycles.
module mdr_word_assembler
   import mdr_asm_pkg::*;
#(
   parameter int BYTE_W = DEF_BYTE_W,
   parameter int BYTES  = DEF_BYTES,
   parameter int ADDR_W = DEF_ADDR_W,
   localparam int WORD_W = BYTE_W * BYTES,
   localparam int CNT_W  = $clog2(BYTES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_byte,
   input  logic              in_valid,
   output logic              in_ready,
`ifdef MDR_ASM_ENDIAN_EN
   input  logic              big_endian,
`endif
   input  logic              flush,
   output logic [WORD_W-1:0] out_word,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_in,
   output logic [ADDR_W-1:0] addr
);

   localparam int IDX_W = $clog2(BYTES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

   asm_state_t        state;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] asm_reg;
   logic [WORD_W-1:0] next_word;
   logic              be_eff;
   int unsigned       lane;
   logic              handshake;

`ifdef MDR_ASM_ENDIAN_EN
   logic be_q;

   // Endianness is latched with the first byte so mid-word toggles are harmless.
   assign be_eff = (idx == '0) ? big_endian : be_q;

   always_ff @(posedge clk) begin
      if (rst)                                           be_q <= 1'b0;
      else if (state == COLLECT && in_valid && idx == '0) be_q <= big_endian;
   end
`else
   assign be_eff = 1'b0;
`endif

   assign in_ready  = (state == COLLECT);
   assign handshake = (state == HOLD) && out_ready;

   always_comb begin
      lane      = lane_index(32'(idx), be_eff, BYTES);
      next_word = asm_reg;
      for (int k = 0; k < BYTES; k++) begin
         if (k == int'(lane)) next_word[k*BYTE_W +: BYTE_W] = in_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         idx       <= '0;
         asm_reg   <= '0;
         out_word  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  if (idx == IDX_LAST || flush) begin
                     out_word  <= next_word;
                     out_count <= CNT_W'(idx) + CNT_W'(1);
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     asm_reg <= next_word;
                     idx     <= idx + IDX_W'(1);
                  end
               end else if (flush && idx != '0) begin
                  out_word  <= asm_reg;
                  out_count <= CNT_W'(idx);
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  idx       <= '0;
                  asm_reg   <= '0;
                  state     <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

   mdr_addr_counter #(.ADDR_W(ADDR_W)) u_addr (
      .clk      (clk),
      .rst      (rst),
      .load     (addr_load),
      .load_val (addr_in),
      .inc      (handshake),
      .addr     (addr)
   );

endmodule

// File: tb/tb_mdr_word_assembler.sv
// Directed self-checking bench for mdr_word_assembler (BYTES=2 and BYTES=4 instances).
module tb_mdr_word_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_ready;
   logic        big_endian;
   logic        flush;
   logic [15:0] out_word;
   logic [1:0]  out_count;
   logic        out_valid;
   logic        out_ready;
   logic        addr_load;
   logic [15:0] addr_in;
   logic [15:0] addr;

   logic [7:0]  in_byte4;
   logic        in_valid4;
   logic        in_ready4;
   logic [31:0] out_word4;
   logic [2:0]  out_count4;
   logic        out_valid4;
   logic [15:0] addr4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mdr_word_assembler #(.BYTE_W(8), .BYTES(2), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MDR_ASM_ENDIAN_EN
      .big_endian(big_endian),
`endif
      .flush(flush), .out_word(out_word), .out_count(out_count), .out_valid(out_valid),
      .out_ready(out_ready), .addr_load(addr_load), .addr_in(addr_in), .addr(addr)
   );

   mdr_word_assembler #(.BYTE_W(8), .BYTES(4), .ADDR_W(16)) dut4 (
      .clk(clk), .rst(rst), .in_byte(in_byte4), .in_valid(in_valid4), .in_ready(in_ready4),
`ifdef MDR_ASM_ENDIAN_EN
      .big_endian(1'b0),
`endif
      .flush(1'b0), .out_word(out_word4), .out_count(out_count4), .out_valid(out_valid4),
      .out_ready(1'b1), .addr_load(1'b0), .addr_in(16'h0000), .addr(addr4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic f);
      in_byte  = b;
      in_valid = 1'b1;
      flush    = f;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; big_endian = 1'b0; flush = 1'b0;
      out_ready = 1'b0; addr_load = 1'b0; addr_in = 16'h0000;
      in_byte4 = 8'h00; in_valid4 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_word",  64'(out_word),  64'h0);
      chk("rst_out_count", 64'(out_count), 64'h0);
      chk("rst_addr",      64'(addr),      64'h0);
      chk("rst_in_ready",  64'(in_ready),  64'h1);

      // Little-endian word with consumer always ready
      out_ready = 1'b1;
      send(8'h34, 1'b0);
      chk("le_no_valid_mid", 64'(out_valid), 64'h0);
      send(8'h12, 1'b0);
      chk("le_valid", 64'(out_valid), 64'h1);
      chk("le_word",  64'(out_word),  64'h1234);
      chk("le_count", 64'(out_count), 64'h2);
      chk("le_in_ready_hold", 64'(in_ready), 64'h0);
      tick();
      chk("le_valid_one_cycle", 64'(out_valid), 64'h0);
      chk("le_addr_inc", 64'(addr), 64'h1);
      out_ready = 1'b0;

      // Backpressure: pending word must not move, input stalled
      send(8'hEF, 1'b0);
      send(8'hBE, 1'b0);
      in_byte = 8'hAA; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_in_ready", 64'(in_ready), 64'h0);
         chk("bp_word",     64'(out_word), 64'hBEEF);
      end
      handshake();
      chk("bp_addr", 64'(addr), 64'h2);
      chk("bp_in_ready_after", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("bp_aa_word",  64'(out_word),  64'h00AA);
      chk("bp_aa_count", 64'(out_count), 64'h1);
      handshake();
      chk("bp_aa_addr", 64'(addr), 64'h3);

      // Flush after one byte
      send(8'h5A, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'h1);
      chk("fl_word",  64'(out_word),  64'h005A);
      chk("fl_count", 64'(out_count), 64'h1);
      handshake();
      chk("fl_addr", 64'(addr), 64'h4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_idx0_ignored", 64'(out_valid), 64'h0);
      chk("fl_idx0_in_ready", 64'(in_ready), 64'h1);
      send(8'h66, 1'b1);
      chk("fl_same_cycle_word",  64'(out_word),  64'h0066);
      chk("fl_same_cycle_count", 64'(out_count), 64'h1);
      handshake();
      send(8'h11, 1'b0);
      send(8'h22, 1'b1);
      chk("fl_complete_word",  64'(out_word),  64'h2211);
      chk("fl_complete_count", 64'(out_count), 64'h2);
      handshake();
      chk("fl_complete_addr", 64'(addr), 64'h6);

      // Address load and wrap; load beats simultaneous increment
      addr_load = 1'b1; addr_in = 16'hFFFF;
      tick();
      addr_load = 1'b0;
      chk("ad_load", 64'(addr), 64'hFFFF);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      handshake();
      chk("ad_wrap", 64'(addr), 64'h0000);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      addr_load = 1'b1; addr_in = 16'h0100;
      handshake();
      addr_load = 1'b0;
      chk("ad_load_prio", 64'(addr), 64'h0100);
      chk("ad_hs_done", 64'(out_valid), 64'h0);

      // Reset mid-word discards the partial byte
      send(8'h77, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_valid", 64'(out_valid), 64'h0);
      chk("mr_word",  64'(out_word),  64'h0);
      chk("mr_count", 64'(out_count), 64'h0);
      chk("mr_addr",  64'(addr),      64'h0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      chk("mr_clean_word", 64'(out_word), 64'h0201);
      handshake();

`ifdef MDR_ASM_ENDIAN_EN
      big_endian = 1'b1;
      send(8'h12, 1'b0);
      big_endian = 1'b0;
      send(8'h34, 1'b0);
      chk("be_word", 64'(out_word), 64'h1234);
      handshake();
`endif

      // Four-byte instance
      for (int i = 1; i <= 4; i++) begin
         in_byte4 = 8'(i * 8'h11); in_valid4 = 1'b1;
         tick();
      end
      in_valid4 = 1'b0;
      chk("b4_valid", 64'(out_valid4), 64'h1);
      chk("b4_word",  64'(out_word4),  64'h44332211);
      chk("b4_count", 64'(out_count4), 64'h4);
      tick();
      chk("b4_addr", 64'(addr4), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
